// File: rtl/iob_cache_arbiter.sv
// iob_cache_arbiter: round-robin arbiter sharing one cache front-end port among N_REQ requesters.
// Define IOB_CACHE_ARB_TIMEOUT_EN to add the err_o watchdog that aborts stalled transactions.
module iob_cache_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      cke_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
    input  logic [N_REQ*DATA_W/8-1:0] req_wstrb_i,
    output logic [N_REQ-1:0]          req_ack_o,
    output logic [N_REQ-1:0]          resp_valid_o,
    output logic [DATA_W-1:0]         resp_rdata_o,
    output logic                      mem_valid_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    output logic [DATA_W/8-1:0]       mem_wstrb_o,
    input  logic                      mem_ack_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    output logic [N_REQ-1:0]          grant_o,
`ifdef IOB_CACHE_ARB_TIMEOUT_EN
    output logic                      err_o,
`endif
    output logic                      busy_o
);
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int STRB_W = DATA_W / 8;

    if (N_REQ < 2 || DATA_W % 8 != 0 || TIMEOUT_W < 1) begin : g_bad_params
        $error("iob_cache_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

    state_t              state_reg, state_next;
    logic [IDX_W-1:0]    ptr_reg, ptr_next;
    logic [IDX_W-1:0]    gidx_reg, gidx_next;
    logic [N_REQ-1:0]    grant_reg, grant_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic [N_REQ-1:0]    ack_pulse, resp_pulse;
    logic                resp_fire;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx, cand, ptr_inc;

    logic [ADDR_W-1:0]   req_addr  [N_REQ];
    logic [DATA_W-1:0]   req_wdata [N_REQ];
    logic [STRB_W-1:0]   req_wstrb [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_addr[gi]  = req_addr_i[gi*ADDR_W +: ADDR_W];
        assign req_wdata[gi] = req_wdata_i[gi*DATA_W +: DATA_W];
        assign req_wstrb[gi] = req_wstrb_i[gi*STRB_W +: STRB_W];
    end

    // First valid requester at or above ptr, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (int'(ptr_reg) + i >= N_REQ) ? IDX_W'(int'(ptr_reg) + i - N_REQ)
                                                : IDX_W'(int'(ptr_reg) + i);
            if (!sel_found && req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign ptr_inc = (gidx_reg == IDX_W'(N_REQ - 1)) ? '0 : gidx_reg + 1'b1;

`ifdef IOB_CACHE_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt_reg;
    logic                 err_pulse;
`endif

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        gidx_next  = gidx_reg;
        grant_next = grant_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wstrb_next = wstrb_reg;
        rdata_next = rdata_reg;
        ack_pulse  = '0;
        resp_pulse = '0;
        resp_fire  = 1'b0;
`ifdef IOB_CACHE_ARB_TIMEOUT_EN
        err_pulse  = 1'b0;
`endif
        if (cke_i) begin
            case (state_reg)
                IDLE: begin
                    if (sel_found) begin
                        gidx_next  = sel_idx;
                        grant_next = N_REQ'(1) << sel_idx;
                        addr_next  = req_addr[sel_idx];
                        wdata_next = req_wdata[sel_idx];
                        wstrb_next = req_wstrb[sel_idx];
                        state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ack_i) begin
                        ack_pulse[gidx_reg] = 1'b1;
                        ptr_next            = ptr_inc;
                        if (wstrb_reg != '0 || mem_rvalid_i) begin
                            resp_fire  = (wstrb_reg == '0);
                            grant_next = '0;
                            state_next = IDLE;
                        end else begin
                            state_next = WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (mem_rvalid_i) begin
                        resp_fire  = 1'b1;
                        grant_next = '0;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
            if (resp_fire) begin
                resp_pulse[gidx_reg] = 1'b1;
                rdata_next           = mem_rdata_i;
            end
`ifdef IOB_CACHE_ARB_TIMEOUT_EN
            // Watchdog only fires when the transaction made no progress this cycle.
            if (state_reg != IDLE && state_next == state_reg && (&tmo_cnt_reg)) begin
                err_pulse           = 1'b1;
                ack_pulse[gidx_reg] = 1'b1;
                ptr_next            = ptr_inc;
                grant_next          = '0;
                state_next          = IDLE;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            gidx_reg  <= '0;
            grant_reg <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            rdata_reg <= '0;
        end else if (cke_i) begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            gidx_reg  <= gidx_next;
            grant_reg <= grant_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
            rdata_reg <= rdata_next;
        end
    end

`ifdef IOB_CACHE_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tmo_cnt_reg <= '0;
        end else if (cke_i) begin
            if (state_next != state_reg) begin
                tmo_cnt_reg <= '0;
            end else if (state_reg != IDLE) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end
        end
    end

    assign err_o = err_pulse;
`endif

    assign req_ack_o    = ack_pulse;
    assign resp_valid_o = resp_pulse;
    assign resp_rdata_o = resp_fire ? mem_rdata_i : rdata_reg;
    assign mem_valid_o  = (state_reg == ISSUE);
    assign mem_addr_o   = addr_reg;
    assign mem_wdata_o  = wdata_reg;
    assign mem_wstrb_o  = wstrb_reg;
    assign grant_o      = grant_reg;
    assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_iob_cache_arbiter.sv
// Testbench for iob_cache_arbiter: vector table plus hand sequences, checked through request/response scoreboards.
// The watchdog sequence runs only when IOB_CACHE_ARB_TIMEOUT_EN is defined.
module tb_iob_cache_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk = 1'b0;
    logic            arst_n;
    logic            cke;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_wstrb;
    logic [N-1:0]    req_ack_o;
    logic [N-1:0]    resp_valid_o;
    logic [DW-1:0]   resp_rdata_o;
    logic            mem_valid_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic [SW-1:0]   mem_wstrb_o;
    logic            mem_ack;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic [N-1:0]    grant_o;
    logic            busy_o;
`ifdef IOB_CACHE_ARB_TIMEOUT_EN
    logic            err_o;
`endif

    always #5 clk = ~clk;

    iob_cache_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(4)) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .cke_i        (cke),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_wstrb_i  (req_wstrb),
        .req_ack_o    (req_ack_o),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .mem_valid_o  (mem_valid_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wstrb_o  (mem_wstrb_o),
        .mem_ack_i    (mem_ack),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .grant_o      (grant_o),
`ifdef IOB_CACHE_ARB_TIMEOUT_EN
        .err_o        (err_o),
`endif
        .busy_o       (busy_o)
    );

    typedef struct { int idx; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [SW-1:0] wstrb; } txn_t;
    typedef struct { int idx; logic [DW-1:0] rdata; } resp_t;
    typedef struct { logic [N-1:0] mask; bit write; int ack_dly; int rv_dly; logic [DW-1:0] rdata; int exp_g; } vec_t;

    txn_t  sb_req[$];
    resp_t sb_resp[$];
    vec_t  vecs[8];
    int    n_pass  = 0;
    int    n_total = 0;

    function automatic logic [AW-1:0] addr_of(int vi, int k);
        return AW'(32'h100 + (vi << 12) + (k << 4));
    endfunction
    function automatic logic [DW-1:0] wdata_of(int vi, int k);
        return DW'(32'hA000_0000 + (vi << 8) + k);
    endfunction
    function automatic logic [SW-1:0] wstrb_of(bit write, int k);
        return write ? SW'(4'hF ^ k) : '0;
    endfunction
    function automatic logic [N-1:0] onehot(int g);
        return N'(1 << g);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs(int vi, logic [N-1:0] mask, bit write);
        for (int k = 0; k < N; k++) begin
            req_addr[k*AW +: AW]  = addr_of(vi, k);
            req_wdata[k*DW +: DW] = wdata_of(vi, k);
            req_wstrb[k*SW +: SW] = wstrb_of(write, k);
        end
        req_valid = mask;
    endtask

    task automatic push_req(int g, int vi, bit write);
        txn_t t;
        t.idx = g; t.addr = addr_of(vi, g); t.wdata = wdata_of(vi, g); t.wstrb = wstrb_of(write, g);
        sb_req.push_back(t);
    endtask

    task automatic push_resp(int g, logic [DW-1:0] d);
        resp_t r;
        r.idx = g; r.rdata = d;
        sb_resp.push_back(r);
    endtask

    task automatic check_issue(txn_t cur, string tag);
        chk({tag, "_mem_valid"}, mem_valid_o, 1);
        chk({tag, "_grant"}, grant_o, onehot(cur.idx));
        chk({tag, "_addr"}, mem_addr_o, cur.addr);
        chk({tag, "_wdata"}, mem_wdata_o, cur.wdata);
        chk({tag, "_wstrb"}, mem_wstrb_o, cur.wstrb);
    endtask

    task automatic check_resp();
        resp_t r;
        if (resp_valid_o != '0) begin
            if (sb_resp.size() == 0) begin
                chk("resp_unexpected", resp_valid_o, 0);
            end else begin
                r = sb_resp.pop_front();
                chk("resp_valid", resp_valid_o, onehot(r.idx));
                chk("resp_rdata", resp_rdata_o, r.rdata);
            end
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_req_ack"}, req_ack_o, 0);
        chk({tag, "_resp_valid"}, resp_valid_o, 0);
        chk({tag, "_resp_rdata"}, resp_rdata_o, 0);
        chk({tag, "_mem_valid"}, mem_valid_o, 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
        chk({tag, "_mem_wstrb"}, mem_wstrb_o, 0);
        chk({tag, "_grant"}, grant_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
`ifdef IOB_CACHE_ARB_TIMEOUT_EN
        chk({tag, "_err"}, err_o, 0);
`endif
    endtask

    task automatic run_vec(int vi);
        vec_t v;
        txn_t cur;
        bit   rd;
        int   g;
        v  = vecs[vi];
        rd = !v.write;
        g  = v.exp_g;
        // IDLE cycle: a stray rvalid here must be ignored
        drive_reqs(vi, v.mask, v.write);
        push_req(g, vi, v.write);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_0001;
        @(negedge clk);
        chk("idle_busy", busy_o, 0);
        chk("idle_mem_valid", mem_valid_o, 0);
        chk("idle_resp_valid", resp_valid_o, 0);
        tick();
        for (int d = 0; d <= v.ack_dly; d++) begin
            mem_ack    = (d == v.ack_dly);
            mem_rvalid = mem_ack ? (rd && v.rv_dly == 0) : 1'b1;
            mem_rdata  = (mem_ack && mem_rvalid) ? v.rdata : DW'(32'h0BAD_0100 + d);
            if (mem_ack && mem_rvalid) push_resp(g, v.rdata);
            @(negedge clk);
            if (d == 0) cur = sb_req.pop_front();
            check_issue(cur, "issue");
            chk("issue_req_ack", req_ack_o, mem_ack ? onehot(g) : '0);
            if (!mem_ack) chk("issue_noack_resp", resp_valid_o, 0);
            check_resp();
            tick();
        end
        req_valid  = '0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        if (rd) begin
            for (int d = 1; d <= v.rv_dly; d++) begin
                mem_rvalid = (d == v.rv_dly);
                mem_rdata  = mem_rvalid ? v.rdata : DW'(32'h0BAD_0200 + d);
                if (mem_rvalid) push_resp(g, v.rdata);
                @(negedge clk);
                chk("wait_busy", busy_o, 1);
                chk("wait_mem_valid", mem_valid_o, 0);
                chk("wait_req_ack", req_ack_o, 0);
                check_resp();
                tick();
            end
            mem_rvalid = 1'b0;
        end
        mem_rdata = 32'h0BAD_0300;
        @(negedge clk);
        chk("done_busy", busy_o, 0);
        chk("done_grant", grant_o, 0);
        chk("resp_pending", sb_resp.size(), 0);
        if (rd) chk("rdata_held", resp_rdata_o, v.rdata);
        tick();
    endtask

    initial begin
        logic [N-1:0] frz_grant;
        txn_t         cur;

        //        mask     write ack rv  rdata          grant
        vecs[0] = '{4'b0001, 1'b0, 1, 2, 32'hDEADBEEF, 0};
        vecs[1] = '{4'b1111, 1'b1, 0, 0, 32'h0,        1};
        vecs[2] = '{4'b0011, 1'b1, 0, 0, 32'h0,        0};
        vecs[3] = '{4'b0011, 1'b0, 0, 0, 32'h12345678, 1};
        vecs[4] = '{4'b1000, 1'b0, 2, 1, 32'h87654321, 3};
        vecs[5] = '{4'b0110, 1'b1, 1, 0, 32'h0,        1};
        vecs[6] = '{4'b0110, 1'b0, 0, 3, 32'h5A5AA5A5, 2};
        vecs[7] = '{4'b0101, 1'b1, 0, 0, 32'h0,        0};

        arst_n = 1'b0; cke = 1'b1; req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        arst_n = 1'b1;
        tick();

        for (int vi = 0; vi < 8; vi++) run_vec(vi);

        // Clock-enable freeze in WAIT_RESP (ptr=1 -> requester 2 wins)
        drive_reqs(30, 4'b0100, 1'b0);
        @(negedge clk);
        tick();
        mem_ack = 1'b1;
        @(negedge clk);
        chk("cke_issue_ack", req_ack_o, 4'b0100);
        tick();
        mem_ack = 1'b0; cke = 1'b0; req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) frz_grant = grant_o;
            chk("cke_grant", grant_o, 4'b0100);
            chk("cke_grant_hold", grant_o, frz_grant);
            chk("cke_busy", busy_o, 1);
            chk("cke_mem_valid", mem_valid_o, 0);
            chk("cke_addr", mem_addr_o, addr_of(30, 2));
            chk("cke_req_ack", req_ack_o, 0);
            chk("cke_resp_valid", resp_valid_o, 0);
            tick();
        end
        cke = 1'b1; req_valid = '0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        push_resp(2, 32'hCAFEF00D);
        @(negedge clk);
        check_resp();
        chk("cke_resp_pending", sb_resp.size(), 0);
        tick();
        mem_rvalid = 1'b0;

        // Async reset in the middle of ISSUE (ptr=3 -> requester 0 wins)
        drive_reqs(31, 4'b0001, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("pre_rst_mem_valid", mem_valid_o, 1);
        chk("pre_rst_grant", grant_o, 4'b0001);
        #1 arst_n = 1'b0;
        #1 check_zero("rst_async");
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1; req_valid = '0;
        check_zero("rst_release");
        tick();

        // All four requesters held, writes acked immediately: grants 0,1,2,3,0
        drive_reqs(20, 4'b1111, 1'b1);
        mem_ack = 1'b1;
        for (int t = 0; t < 5; t++) push_req(t % N, 20, 1'b1);
        @(negedge clk);
        chk("rr_idle_req_ack", req_ack_o, 0);
        tick();
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            cur = sb_req.pop_front();
            check_issue(cur, "rr");
            chk("rr_req_ack", req_ack_o, onehot(cur.idx));
            chk("rr_resp_valid", resp_valid_o, 0);
            tick();
            if (t == 4) req_valid = '0;
            @(negedge clk);
            chk("rr_gap_busy", busy_o, 0);
            chk("rr_gap_req_ack", req_ack_o, 0);
            tick();
        end
        mem_ack = 1'b0;

`ifdef IOB_CACHE_ARB_TIMEOUT_EN
        // Cache never acks: abort 15 cycles after entering ISSUE (ptr=1 -> requester 1)
        drive_reqs(40, 4'b0010, 1'b0);
        @(negedge clk);
        tick();
        for (int k = 0; k <= 15; k++) begin
            @(negedge clk);
            chk("tmo_err", err_o, (k == 15) ? 1 : 0);
            chk("tmo_req_ack", req_ack_o, (k == 15) ? 4'b0010 : 4'b0000);
            chk("tmo_resp_valid", resp_valid_o, 0);
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        chk("tmo_idle_busy", busy_o, 0);
        chk("tmo_idle_grant", grant_o, 0);
        chk("tmo_idle_err", err_o, 0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/iob_cache_arbiter.md
Name: iob_cache_arbiter

Overview:
- Round-robin arbiter that shares one cache front-end port between N_REQ native-interface requesters (e.g. PE read/write engines).
- Latches the winning request into internal registers, presents it to the cache, and routes read data back to the granted requester.
- Sits directly in front of the cache, one instance per shared cache port.

Parameters:
- N_REQ, 4, number of requesters; at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; a multiple of 8.
- TIMEOUT_W, 8, watchdog counter width; used only with the optional feature.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_n_i  in  1  asynchronous active-low reset.
- cke_i  in  1  clock enable; when low, all state holds.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_addr_i  in  N_REQ*ADDR_W  packed addresses; requester k occupies slice k.
- req_wdata_i  in  N_REQ*DATA_W  packed write data.
- req_wstrb_i  in  N_REQ*DATA_W/8  packed byte strobes; all zero means read.
- req_ack_o  out  N_REQ  one-cycle pulse: request accepted by the cache.
- resp_valid_o  out  N_REQ  one-cycle pulse: read data valid for requester k.
- resp_rdata_o  out  DATA_W  read data, shared by all requesters; qualified by resp_valid_o.
- mem_valid_o  out  1  request to the cache.
- mem_addr_o  out  ADDR_W  latched address.
- mem_wdata_o  out  DATA_W  latched write data.
- mem_wstrb_o  out  DATA_W/8  latched strobes.
- mem_ack_i  in  1  cache accepts the request this cycle.
- mem_rvalid_i  in  1  cache read data valid.
- mem_rdata_i  in  DATA_W  cache read data.
- grant_o  out  N_REQ  one-hot current owner; zero when idle.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and the priority pointer is 0.
- Clock enable: all registers update only when cke_i=1; when cke_i=0 the outputs hold their values.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - If any req_valid_i bit is set, select the first set bit scanning from ptr upward, wrapping modulo N_REQ.
  - Latch that requester's addr/wdata/wstrb, set grant_o, and go to ISSUE.
  - mem_valid_o rises in the cycle after req_valid_i is sampled (1-cycle latency).
- ISSUE:
  - mem_valid_o=1 with stable payload until mem_ack_i=1.
  - In the ack cycle: pulse req_ack_o[g] and set ptr=(g+1) mod N_REQ.
  - Write (wstrb!=0): go to IDLE and clear grant_o.
  - Read with mem_rvalid_i=1 in the same cycle: pulse resp_valid_o[g], drive resp_rdata_o=mem_rdata_i, go to IDLE.
  - Read otherwise: go to WAIT_RESP.
  - mem_valid_o drops in the cycle after the ack.
- WAIT_RESP:
  - On mem_rvalid_i: pulse resp_valid_o[g], drive resp_rdata_o=mem_rdata_i, clear grant_o, go to IDLE.
  - mem_rvalid_i in IDLE or ISSUE-without-ack is ignored.
- No back-to-back issue: at least one IDLE cycle separates transactions, so the maximum throughput is one request per 2 cycles.
- Requester obligations and arbiter guarantees:
  - A requester holds valid and payload until its req_ack_o.
  - If a requester drops valid after being granted, the latched transaction still completes.
  - A non-granted requester is never acked.
- resp_rdata_o holds its last value between responses.
- Reset asserted mid-transaction clears all state immediately. The cache side must be reset together with the arbiter.

Optional Feature:
- Macro: IOB_CACHE_ARB_TIMEOUT_EN.
- Enabled:
  - Adds output port err_o (1 bit, reset 0).
  - A TIMEOUT_W-bit counter clears on entering ISSUE or WAIT_RESP and increments every enabled cycle spent in those states.
  - When the counter reaches all-ones, the FSM aborts to IDLE. It pulses err_o and req_ack_o[g] together for one cycle, clears grant_o, and gives no resp_valid_o.
  - The pointer advances to g+1.
- Disabled:
  - No err_o port and no counter.
  - The arbiter waits indefinitely in ISSUE and WAIT_RESP.

Test Plan:
1. Reset, then req_valid_i=4'b0001 as a read at addr 0x100; cache acks in cycle 2 and gives rvalid with 0xDEADBEEF in cycle 4 -> mem_valid_o high in cycles 1-2, req_ack_o[0] pulse in cycle 2, resp_valid_o[0] pulse with resp_rdata_o=0xDEADBEEF in cycle 4, busy_o low in cycle 5.
2. req_valid_i=4'b1111 held, all writes, cache acks immediately -> grants in order 0,1,2,3,0, one ack every 2 cycles, and no resp_valid_o pulses.
3. ptr=2 after a grant to 1, then req_valid_i=4'b0011 -> grant goes to 0 (wrap), and the next grant goes to 1.
4. Read where mem_ack_i and mem_rvalid_i arrive in the same cycle -> req_ack_o[g] and resp_valid_o[g] pulse in the same cycle, WAIT_RESP is skipped, and the FSM is back in IDLE next cycle.
5. cke_i=0 for 3 cycles during WAIT_RESP with mem_rvalid_i low, then arst_n_i=0 mid-ISSUE -> outputs frozen while cke_i=0; after reset all outputs are 0 and ptr=0.
6. With IOB_CACHE_ARB_TIMEOUT_EN and TIMEOUT_W=4, the cache never acks -> err_o and req_ack_o[g] pulse together 15 cycles after entering ISSUE, then the FSM returns to IDLE.
